spm_result_display: RTL and testbench

- Downstream consumer of the divided scan clock from the clock divider in the signed 8x8 SPM FPGA design.
- Takes the signed 16-bit product from the multiplier and converts it to sign plus 5 BCD digits with a sequential double-dabble engine.
- Time-multiplexes a 4-digit 7-segment display, advancing one digit per rising edge of the divided clock.
- A scroll input selects which 4 of the 6 characters are shown.

---
 rtl/spm_disp_pkg.sv | 21 ++
 rtl/spm_result_display_if.sv | 12 +
 rtl/bin2bcd_seq.sv | 55 +++++
 rtl/spm_result_display.sv | 64 ++++++
 tb/tb_spm_result_display.sv | 137 +++++++++++++
 5 files changed

// File: rtl/spm_disp_pkg.sv
// spm_disp_pkg: shared FSM states, segment constants and BCD glyph lookup
package spm_disp_pkg;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/spm_result_display_if.sv
// spm_result_display_if: product strobe from the multiplier and display pins
interface spm_result_display_if;
  logic [15:0] prod;
  logic        prod_valid;
  logic [1:0]  scroll;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  modport master (output prod, prod_valid, scroll, input busy, an, seg, dp);
  modport slave  (input prod, prod_valid, scroll, output busy, an, seg, dp);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: signed 16-bit to sign + 5 BCD digits, one double-dabble step per clk
module bin2bcd_seq
  import spm_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic        neg,
  output logic [19:0] bcd
);
  state_t      state;
  logic [15:0] mag;
  logic [3:0]  cnt;
  logic [19:0] adj;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 5; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      neg   <= 1'b0;
      mag   <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          mag   <= bin[15] ? 16'(-bin) : bin;
          neg   <= bin[15];
          bcd   <= '0;
          cnt   <= 4'd15;
          busy  <= 1'b1;
          state <= CONV;
        end
        CONV: begin
          {bcd, mag} <= {adj, mag} << 1;
          cnt        <= cnt - 4'd1;
          done       <= cnt == 4'd0;
          state      <= cnt == 4'd0 ? LOAD : CONV;
        end
        LOAD: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: rtl/spm_result_display.sv
// spm_result_display: converts the SPM product to decimal and scans it onto a
// 4-digit 7-segment display with a selectable 4-of-6 character window
module spm_result_display
  import spm_disp_pkg::*;
#(
  parameter int PW            = 16,
  parameter bit AN_ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst,
  input logic scan_clk,
  spm_result_display_if.slave bus
);
  localparam logic [3:0] AN_OFF = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  logic [PW-1:0] prod;
  logic          s1, s2, s3, scan_tick;
  logic          done, neg, disp_neg;
  logic [19:0]   bcd, disp_bcd;
  logic [4:0]    nz;
  logic [6:0]    chr [6];
  logic [2:0]    pos;
  logic [1:0]    idx;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  assign prod      = bus.prod;
  assign scan_tick = s2 & ~s3;
  assign bus.an    = an_r;
  assign bus.seg   = seg_r;
  assign bus.dp    = 1'b1;
  bin2bcd_seq u_conv (
    .clk, .rst, .start(bus.prod_valid), .bin(prod),
    .busy(bus.busy), .done, .neg, .bcd
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {scan_clk, s1, s2};
  // Double buffer: the scan only ever sees completed conversions
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      disp_bcd <= '0;
      disp_neg <= 1'b0;
    end else if (done) begin
      disp_bcd <= bcd;
      disp_neg <= neg;
    end
  always_comb begin
    for (int i = 0; i < 5; i++) nz[i] = disp_bcd[4*i +: 4] != 4'd0;
    chr[0] = bcd_to_seg(disp_bcd[3:0]);
    for (int i = 1; i < 5; i++)
      chr[i] = (nz >> i) != 5'd0 ? bcd_to_seg(disp_bcd[4*i +: 4]) : SEG_BLANK;
    chr[5] = disp_neg && nz != 5'd0 ? SEG_MINUS : SEG_BLANK;
    pos = {1'b0, idx} + (bus.scroll[1] ? 3'd2 : {2'b0, bus.scroll[0]});
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx   <= '0;
      an_r  <= AN_OFF;
      seg_r <= SEG_BLANK;
    end else if (scan_tick) begin
      an_r  <= AN_ACTIVE_LOW ? ~(4'b0001 << idx) : 4'b0001 << idx;
      seg_r <= chr[pos];
      idx   <= idx + 2'd1;
    end
endmodule

// File: tb/tb_spm_result_display.sv
// tb_spm_result_display: directed checks of conversion, blanking, scroll and reset
module tb_spm_result_display;
  logic clk = 1'b0, rst = 1'b1, scan_clk = 1'b0;
  int checks = 0, errors = 0;
  int n;
  logic [3:0] a;
  logic [6:0] shown [4];
  localparam logic [6:0] BL = 7'h7F, MI = 7'b0111111;
  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G6 = 7'b0000010,
                         G7 = 7'b1111000, G8 = 7'b0000000;
  spm_result_display_if bus ();
  spm_result_display #(.PW(16), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .scan_clk(scan_clk), .bus(bus.slave)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scan_one(output logic [3:0] an_seen);
    @(negedge clk) scan_clk = 1'b1;
    repeat (4) @(negedge clk);
    an_seen = bus.an;
    for (int k = 0; k < 4; k++) if (bus.an[k] == 1'b0) shown[k] = bus.seg;
    scan_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_disp(input string tag, input logic [6:0] e3, e2, e1, e0);
    logic [3:0] t;
    for (int k = 0; k < 4; k++) shown[k] = 7'hXX;
    repeat (4) scan_one(t);
    chk({tag, "_an3"}, 32'(shown[3]), 32'(e3));
    chk({tag, "_an2"}, 32'(shown[2]), 32'(e2));
    chk({tag, "_an1"}, 32'(shown[1]), 32'(e1));
    chk({tag, "_an0"}, 32'(shown[0]), 32'(e0));
  endtask

  task automatic pulse(input logic [15:0] v);
    @(negedge clk);
    bus.prod = v;
    bus.prod_valid = 1'b1;
    @(negedge clk) bus.prod_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 1;
    while (bus.busy && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
    cycles--;
    chk("busy_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.prod = '0;
    bus.prod_valid = 1'b0;
    bus.scroll = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("an_idle_before_tick", 32'(bus.an), 32'hF);
    scan_one(a); chk("scan_an_0", 32'(a), 32'b1110);
    chk("rst_d0", 32'(bus.seg), 32'(G0));
    scan_one(a); chk("scan_an_1", 32'(a), 32'b1101);
    chk("rst_d1", 32'(bus.seg), 32'(BL));
    scan_one(a); chk("scan_an_2", 32'(a), 32'b1011);
    scan_one(a); chk("scan_an_3", 32'(a), 32'b0111);
    chk("rst_d3", 32'(bus.seg), 32'(BL));

    pulse(16'hC000);
    wait_idle(n);
    chk("busy_cycles", 32'(n), 32'd17);
    check_disp("m16384_s0", G6, G3, G8, G4);
    bus.scroll = 2'd2;
    check_disp("m16384_s2", MI, G1, G6, G3);
    bus.scroll = 2'd1;
    check_disp("m16384_s1", G1, G6, G3, G8);

    bus.scroll = 2'd0;
    pulse(16'h0038);
    wait_idle(n);
    check_disp("p56_s0", BL, BL, G0 ^ 7'h00 ^ 7'b0010010 ^ G0, G6);
    bus.scroll = 2'd2;
    check_disp("p56_s2", BL, BL, BL, BL);
    bus.scroll = 2'd3;
    check_disp("p56_s3", BL, BL, BL, BL);

    pulse(16'hFFFF);
    wait_idle(n);
    chk("neg_reg", 32'(dut.disp_neg), 32'd1);
    bus.scroll = 2'd2;
    check_disp("m1_s2", MI, BL, BL, BL);
    bus.scroll = 2'd0;
    check_disp("m1_s0", BL, BL, BL, G1);

    pulse(16'h1234);
    repeat (2) @(negedge clk);
    bus.prod = 16'h0005;
    bus.prod_valid = 1'b1;
    @(negedge clk) bus.prod_valid = 1'b0;
    wait_idle(n);
    repeat (10) @(negedge clk);
    chk("no_queued_start", 32'(bus.busy), 32'd0);
    check_disp("p4660_s0", G4, G6, G6, G0);

    pulse(16'h0100);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_an", 32'(bus.an), 32'hF);
    chk("midrst_seg", 32'(bus.seg), 32'h7F);
    @(negedge clk) rst = 1'b0;
    check_disp("midrst_disp", BL, BL, BL, G0);
    pulse(16'h8000);
    wait_idle(n);
    chk("busy_cycles_2", 32'(n), 32'd17);
    check_disp("m32768_s0", G2, G7, G6, G8);
    bus.scroll = 2'd2;
    check_disp("m32768_s2", MI, G3, G2, G7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
